// File: rtl/act_fetch_ctrl_pkg.sv
// Shared parameters for the activation fetch stage.
//   DATA_W_DEF  activation word width
//   ADDR_W_DEF  SRAM word address width
//   FIFO_D_DEF  output buffer depth (power of 2, >= 2)
//   PEND_W_DEF  outstanding-request counter width
//   c_log_2()   ceiling log2, used for pointer and count widths
package act_fetch_ctrl_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned FIFO_D_DEF = 4;
   localparam int unsigned PEND_W_DEF = 4;

   function automatic int unsigned c_log_2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/act_fetch_ctrl_if.sv
// SRAM read bus and PE-array valid/ready handshake of the activation fetch stage.
//   SRAM_RdEn/SRAM_RdAddr/SRAM_BankSel  read request, driven by the fetch stage
//   SRAM_RdDat                          read data, valid the cycle after SRAM_RdEn
//   PE_ActDat/PE_ActVld                 activation word offered to the PE array
//   PE_ActRdy                           PE array accepts the word
// master: fetch stage side; slave: SRAM + PE array side.
interface act_fetch_ctrl_if import act_fetch_ctrl_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   logic              SRAM_RdEn;
   logic [ADDR_W-1:0] SRAM_RdAddr;
   logic              SRAM_BankSel;
   logic [DATA_W-1:0] SRAM_RdDat;
   logic [DATA_W-1:0] PE_ActDat;
   logic              PE_ActVld;
   logic              PE_ActRdy;

   modport master (
      output SRAM_RdEn, SRAM_RdAddr, SRAM_BankSel, PE_ActDat, PE_ActVld,
      input  SRAM_RdDat, PE_ActRdy
   );

   modport slave (
      input  SRAM_RdEn, SRAM_RdAddr, SRAM_BankSel, PE_ActDat, PE_ActVld,
      output SRAM_RdDat, PE_ActRdy
   );
endinterface

// File: rtl/act_out_fifo.sv
// Synchronous FIFO buffering returned activation words (DATA_W x DEPTH).
//   clk, rst  clock / asynchronous active-high reset
//   push/din  write din at the clock edge (ignored when full without a pop)
//   pop       advance the head (ignored when empty)
//   dout      head word, straight from registered storage
//   count     number of stored words; empty/full flags derived from it
// Push and pop in the same cycle keep count unchanged, including when full.
module act_out_fifo import act_fetch_ctrl_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = FIFO_D_DEF,
   localparam int unsigned PTR_W = c_log_2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/act_fetch_ctrl.sv
// Activation fetch stage: turns controller fetch pulses into activation SRAM reads
// (1-cycle latency), buffers the returned words and hands them to the PE array over
// valid/ready. Each accepted word strobes CTRLACT_GetAct back to the controller.
//   clk, rst          clock / asynchronous active-high reset
//   CTRLACT_PlsFetch  fetch request pulse, one word per high cycle
//   CTRLACT_FnhFrm    frame finish: toggles the ping-pong bank, clears the address
//   CFG_NumAct        words per frame minus 1
//   CTRLACT_GetAct    one-cycle strobe per word accepted by the PE array
//   ERR_PendOvf       sticky: fetch pulse dropped at a saturated pending counter
//   bus               SRAM read bus + PE handshake (act_fetch_ctrl_if.master)
// A read issues the cycle after its pulse; PE_ActVld rises two cycles after the issue.
module act_fetch_ctrl import act_fetch_ctrl_pkg::*; #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned FIFO_D = FIFO_D_DEF,
   parameter int unsigned PEND_W = PEND_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CTRLACT_PlsFetch,
   input  logic              CTRLACT_FnhFrm,
   input  logic [ADDR_W-1:0] CFG_NumAct,
   output logic              CTRLACT_GetAct,
   output logic              ERR_PendOvf,
   act_fetch_ctrl_if.master  bus
);

   localparam int unsigned     CNT_W   = c_log_2(FIFO_D) + 1;
   localparam logic [CNT_W-1:0] ALMOST = CNT_W'(FIFO_D - 1);

   logic [PEND_W-1:0] pending;
   logic              inflight;
   logic [ADDR_W-1:0] addr;
   logic              bank;
   logic              rd_en;
   logic              pop;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_empty;
   logic              fifo_full;

   // Credit rule fifo_cnt + inflight < FIFO_D, split so the FIFO flags do the work:
   // room exists unless full, or one slot left that the in-flight word will take.
   assign rd_en = (pending != '0) && !fifo_full && !(inflight && (fifo_cnt == ALMOST));
   assign pop   = !fifo_empty && bus.PE_ActRdy;

   assign bus.SRAM_RdEn    = rd_en;
   assign bus.SRAM_RdAddr  = addr;
   assign bus.SRAM_BankSel = bank;
   assign bus.PE_ActVld    = !fifo_empty;
   assign CTRLACT_GetAct   = pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending     <= '0;
         inflight    <= 1'b0;
         addr        <= '0;
         bank        <= 1'b0;
         ERR_PendOvf <= 1'b0;
      end else begin
         inflight <= rd_en;

         // A pulse coinciding with an issue leaves pending unchanged, even when saturated.
         if (CTRLACT_PlsFetch && !rd_en) begin
            if (pending == '1) ERR_PendOvf <= 1'b1;
            else               pending     <= pending + 1'b1;
         end else if (!CTRLACT_PlsFetch && rd_en) begin
            pending <= pending - 1'b1;
         end

         // Frame finish wins over increment; a read issued this cycle already used old addr/bank.
         if (CTRLACT_FnhFrm) begin
            addr <= '0;
            bank <= ~bank;
         end else if (rd_en) begin
            addr <= (addr == CFG_NumAct) ? '0 : addr + 1'b1;
         end
      end
   end

   // The SRAM returns data the cycle after an issue; inflight marks that cycle as a push.
   act_out_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_D)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .pop   (pop),
      .din   (bus.SRAM_RdDat),
      .dout  (bus.PE_ActDat),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_act_fetch_ctrl.sv
// Self-checking bench for act_fetch_ctrl: a per-cycle vector table for single fetch,
// pulse/issue and frame/issue coincidence, plus hand sequences for reset, back-pressure,
// address wrap with frame switch, and pending overflow.
module tb_act_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pls;
   logic       fnh;
   logic [9:0] num_act;
   logic       get;
   logic       err;

   int tests = 0;
   int fails = 0;

   logic [10:0] issue_q[$];
   logic [63:0] get_q[$];

   always #5 clk = ~clk;

   act_fetch_ctrl_if #(.DATA_W(64), .ADDR_W(10)) bus ();

   act_fetch_ctrl #(
      .DATA_W (64),
      .ADDR_W (10),
      .FIFO_D (4),
      .PEND_W (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .CTRLACT_PlsFetch (pls),
      .CTRLACT_FnhFrm   (fnh),
      .CFG_NumAct       (num_act),
      .CTRLACT_GetAct   (get),
      .ERR_PendOvf      (err),
      .bus              (bus)
   );

   function automatic logic [63:0] mk_dat(input logic b, input logic [9:0] a);
      return {32'hACE0_0000, 15'h0, b, 6'h0, a};
   endfunction

   // SRAM model: fixed 1-cycle read latency, junk when not reading
   always @(posedge clk) begin
      if (bus.SRAM_RdEn) bus.SRAM_RdDat <= mk_dat(bus.SRAM_BankSel, bus.SRAM_RdAddr);
      else               bus.SRAM_RdDat <= 64'hDEAD_BEEF_DEAD_BEEF;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.SRAM_RdEn) issue_q.push_back({bus.SRAM_BankSel, bus.SRAM_RdAddr});
         if (get)           get_q.push_back(bus.PE_ActDat);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [9:0] n);
      rst = 1'b1;
      pls = 1'b0;
      fnh = 1'b0;
      bus.PE_ActRdy = 1'b0;
      num_act = n;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      issue_q.delete();
      get_q.delete();
   endtask

   typedef struct {
      logic       pls;
      logic       fnh;
      logic       rdy;
      logic       rden;
      logic [9:0] addr;
      logic       bank;
      logic       vld;
      logic       get;
      logic [9:0] dat_addr;
      logic       dat_bank;
   } vec_t;

   vec_t vecs[15];

   initial begin
      logic seen_vld;

      vecs = '{
         //  pls   fnh   rdy   rden  addr   bank  vld   get   dat addr/bank
         '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 10'd1, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 10'd3, 1'b0, 1'b1, 1'b1, 10'd1, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 10'd3, 1'b0, 1'b1, 1'b1, 10'd2, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 10'd3, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b1, 1'b1, 1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 1'b1, 1'b1, 1'b1, 10'd3, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 10'd1, 1'b1, 1'b1, 1'b1, 10'd0, 1'b1}
      };

      // ---- reset mid-stream: pending=3, FIFO=2, one read in flight ----
      do_reset(10'h3FF);
      for (int i = 0; i < 7; i++) begin
         step();
         pls = 1'b1;
      end
      step();
      pls = 1'b0;
      repeat (3) step();
      chk("rst pre pending", 64'(dut.pending), 64'd3);
      step();
      bus.PE_ActRdy = 1'b1;
      step();
      pls = 1'b1;
      step();
      pls = 1'b0;
      bus.PE_ActRdy = 1'b0;
      chk("rst pre fifo", 64'(dut.u_fifo.count), 64'd2);
      chk("rst pre inflight", 64'(dut.inflight), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst rden", 64'(bus.SRAM_RdEn), 64'd0);
      chk("rst addr", 64'(bus.SRAM_RdAddr), 64'd0);
      chk("rst vld", 64'(bus.PE_ActVld), 64'd0);
      chk("rst dat", bus.PE_ActDat, 64'd0);
      chk("rst get", 64'(get), 64'd0);
      chk("rst pending", 64'(dut.pending), 64'd0);
      step();
      rst = 1'b0;
      bus.PE_ActRdy = 1'b1;
      issue_q.delete();
      get_q.delete();
      seen_vld = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.PE_ActVld) seen_vld = 1'b1;
      end
      chk("rst no vld after release", 64'(seen_vld), 64'd0);
      chk("rst no reads after release", 64'(issue_q.size()), 64'd0);

      // ---- vector table: single fetch, pulse+issue, frame+issue ----
      do_reset(10'd3);
      for (int i = 0; i < 15; i++) begin
         step();
         pls = vecs[i].pls;
         fnh = vecs[i].fnh;
         bus.PE_ActRdy = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d rden", i), 64'(bus.SRAM_RdEn), 64'(vecs[i].rden));
         chk($sformatf("vec%0d addr", i), 64'(bus.SRAM_RdAddr), 64'(vecs[i].addr));
         chk($sformatf("vec%0d bank", i), 64'(bus.SRAM_BankSel), 64'(vecs[i].bank));
         chk($sformatf("vec%0d vld", i), 64'(bus.PE_ActVld), 64'(vecs[i].vld));
         chk($sformatf("vec%0d get", i), 64'(get), 64'(vecs[i].get));
         if (vecs[i].vld)
            chk($sformatf("vec%0d dat", i), bus.PE_ActDat, mk_dat(vecs[i].dat_bank, vecs[i].dat_addr));
      end

      // ---- back-pressure: 8 pulses with PE_ActRdy low ----
      do_reset(10'h3FF);
      for (int i = 0; i < 8; i++) begin
         step();
         pls = 1'b1;
      end
      step();
      pls = 1'b0;
      repeat (6) step();
      @(negedge clk);
      chk("bp reads issued", 64'(issue_q.size()), 64'd4);
      chk("bp pending", 64'(dut.pending), 64'd4);
      chk("bp vld", 64'(bus.PE_ActVld), 64'd1);
      chk("bp head", bus.PE_ActDat, mk_dat(1'b0, 10'd0));
      chk("bp no get", 64'(get_q.size()), 64'd0);
      repeat (3) step();
      @(negedge clk);
      chk("bp head stable", bus.PE_ActDat, mk_dat(1'b0, 10'd0));
      step();
      bus.PE_ActRdy = 1'b1;
      for (int c = 0; c < 60 && get_q.size() < 8; c++) step();
      repeat (5) step();
      chk("bp get total", 64'(get_q.size()), 64'd8);
      for (int k = 0; k < 8 && k < get_q.size(); k++)
         chk($sformatf("bp data%0d", k), get_q[k], mk_dat(1'b0, 10'(k)));

      // ---- wrap at CFG_NumAct=3, then frame switch ----
      do_reset(10'd3);
      bus.PE_ActRdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         pls = 1'b1;
      end
      step();
      pls = 1'b0;
      repeat (8) step();
      chk("wrap read count", 64'(issue_q.size()), 64'd6);
      for (int k = 0; k < 6 && k < issue_q.size(); k++)
         chk($sformatf("wrap addr%0d", k), 64'(issue_q[k]), 64'({1'b0, 10'(k % 4)}));
      fnh = 1'b1;
      step();
      fnh = 1'b0;
      @(negedge clk);
      chk("frm bank", 64'(bus.SRAM_BankSel), 64'd1);
      chk("frm addr", 64'(bus.SRAM_RdAddr), 64'd0);
      step();
      pls = 1'b1;
      step();
      pls = 1'b0;
      repeat (5) step();
      chk("frm read count", 64'(issue_q.size()), 64'd7);
      if (issue_q.size() > 0)
         chk("frm next read", 64'(issue_q[issue_q.size()-1]), 64'({1'b1, 10'd0}));
      if (get_q.size() > 0)
         chk("frm next data", get_q[get_q.size()-1], mk_dat(1'b1, 10'd0));

      // ---- pending overflow: 24 pulses with PE_ActRdy low ----
      do_reset(10'h3FF);
      for (int i = 0; i < 24; i++) begin
         step();
         pls = 1'b1;
         @(negedge clk);
         if (i == 19) begin
            chk("ovf pending at 19 pulses", 64'(dut.pending), 64'd15);
            chk("ovf err not yet", 64'(err), 64'd0);
         end
      end
      step();
      pls = 1'b0;
      @(negedge clk);
      chk("ovf pending sat", 64'(dut.pending), 64'd15);
      chk("ovf err set", 64'(err), 64'd1);
      step();
      bus.PE_ActRdy = 1'b1;
      for (int c = 0; c < 200 && get_q.size() < 19; c++) step();
      repeat (10) step();
      chk("ovf delivered", 64'(get_q.size()), 64'd19);
      if (get_q.size() > 0)
         chk("ovf last data", get_q[get_q.size()-1], mk_dat(1'b0, 10'(get_q.size() - 1)));
      chk("ovf err sticky", 64'(err), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
